// File: rtl/counter_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : counter_arbiter                                                 |
// | Purpose  : Round-robin arbiter that gives two requesters turns at a shared |
// |            up/down counter (load/clear/subtract controls, Moore outputs).  |
// | Options  : CTR_ARB_NAK_EN - adds nak0/nak1 and completes illegal requests  |
// |            with a nak pulse instead of an ack.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module counter_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic dir0,
    input  logic dir1,
    input  logic CM,
    input  logic Cm,
    output logic ld,
    output logic clr,
    output logic s,
    output logic gnt0,
    output logic gnt1,
    output logic ack0,
    output logic ack1,
`ifdef CTR_ARB_NAK_EN
    output logic nak0,
    output logic nak1,
`endif
    output logic busy
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic r_last;
    logic r_owner;
    logic r_dir;
    logic w_any_req;
    logic w_sel;
    logic w_sel_dir;
    logic w_sel_legal;

    // Requester selection, evaluated only while IDLE; a tie goes to whoever
    // was not served last.
    always_comb begin
        w_any_req = req0 | req1;
        if (req0 && req1) begin
            w_sel = ~r_last;
        end else begin
            w_sel = req1;
        end
        w_sel_dir   = w_sel ? dir1 : dir0;
        w_sel_legal = w_sel_dir ? Cm : CM;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT: w_next = ST_IDLE;
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next = w_sel_legal ? ST_EXEC : ST_DONE;
                end
            end
            ST_EXEC: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_any_req) begin
                r_owner <= w_sel;
                r_dir   <= w_sel_dir;
            end
            if (r_state == ST_DONE) begin
                r_last <= r_owner;
            end
        end
    end

`ifdef CTR_ARB_NAK_EN
    // Legality is only observable through the ack/nak choice in DONE.
    logic r_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_legal <= 1'b0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_legal <= w_sel_legal;
        end
    end
`endif

    always_comb begin
        ld   = 1'b0;
        clr  = 1'b0;
        s    = 1'b0;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        ack0 = 1'b0;
        ack1 = 1'b0;
`ifdef CTR_ARB_NAK_EN
        nak0 = 1'b0;
        nak1 = 1'b0;
`endif
        busy = (r_state != ST_IDLE);
        case (r_state)
            ST_INIT: clr = 1'b1;
            ST_EXEC: begin
                ld   = 1'b1;
                s    = r_dir;
                gnt0 = ~r_owner;
                gnt1 = r_owner;
            end
            ST_DONE: begin
`ifdef CTR_ARB_NAK_EN
                ack0 = r_legal & ~r_owner;
                ack1 = r_legal & r_owner;
                nak0 = ~r_legal & ~r_owner;
                nak1 = ~r_legal & r_owner;
`else
                ack0 = ~r_owner;
                ack1 = r_owner;
`endif
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 req0, req1  input  1 each  level request from requester 0 or 1; held until its ack (or nak) pulse.
REQ-005 dir0, dir1  input  1 each  requested direction: 0 = increment, 1 = decrement; valid while the matching req is high.
REQ-006 CM  input  1  datapath flag: count below maximum (increment legal).
REQ-007 Cm  input  1  datapath flag: count above minimum (decrement legal).
REQ-008 ld, clr, s  output  1 each  shared counter controls: load, clear, subtract select.
REQ-009 gnt0, gnt1  output  1 each  the matching requester owns the datapath this cycle.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse to the matching requester.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have the states INIT, IDLE, EXEC and DONE, and all outputs SHALL be Moore (decoded from state plus latched registers only).
REQ-013 INIT SHALL drive clr=1 and ld=0, and SHALL move unconditionally to IDLE.
REQ-014 IDLE SHALL drive all outputs 0; with no req high it SHALL stay in IDLE.
REQ-015 In IDLE, with exactly one req high, that requester SHALL be selected; with both high, the requester not granted last SHALL be selected (round-robin via a 1-bit last pointer).
REQ-016 On selection, the arbiter SHALL latch the owner id and its dir, and SHALL latch legal = (dir==0 ? CM : Cm), sampled on the same edge.
REQ-017 When legal=1, the arbiter SHALL go to EXEC; when legal=0, it SHALL go directly to DONE with no ld pulse (but see REQ-026).
REQ-018 EXEC SHALL last one cycle and drive ld=1, s=latched dir, clr=0 and gnt of the owner =1; it SHALL then go to DONE.
REQ-019 DONE SHALL last one cycle and drive the owner's ack=1; it SHALL update last to the owner id and return to IDLE.
REQ-020 Latency: req high at IDLE edge E -> ld high in the cycle after E -> ack high in the cycle after E+1 -> IDLE after E+2, for a minimum of 3 cycles per transaction.
REQ-021 Only the owner's gnt/ack SHALL ever assert; gnt0&gnt1 and ack0&ack1 SHALL never both be 1.
REQ-022 Changes on req, dir, CM or Cm outside IDLE SHALL be ignored until the next IDLE evaluation.
REQ-023 A req still high in the IDLE cycle after its ack SHALL be treated as a new request, subject to round-robin.

Reset
REQ-024 rst=1 at a clock edge SHALL force the state to INIT from any state (including mid-EXEC/DONE), and SHALL set last=1 (req0 wins the first tie) and owner/dir/legal=0. No ack SHALL be issued for an aborted transaction.
REQ-025 Reset values: while in reset and in the first cycle after it, the outputs SHALL be clr=1, busy=1 and all others 0; in the following cycle the FSM SHALL be in IDLE.

Configuration
REQ-026 Macro CTR_ARB_NAK_EN:
- Defined: outputs nak0 and nak1 (output, 1 bit each) SHALL exist, and an illegal request (legal=0) SHALL complete in DONE with a nak pulse instead of an ack.
- Undefined: no nak ports SHALL exist, and an illegal request SHALL complete in DONE with ack (a silent drop).

Verification
REQ-027 Reset check: assert rst for 2 cycles then release -> clr=1 for exactly one cycle after release, then IDLE with all outputs 0.
REQ-028 Single increment: req0=1, dir0=0, CM=1 -> the next cycle has ld=1, s=0, gnt0=1; the cycle after has ack0=1; 3 cycles total.
REQ-029 Tie: req0=req1=1 held continuously after reset -> grant order 0,1,0,1; ack pulses every 3 cycles.
REQ-030 Illegal decrement: req1=1, dir1=1, Cm=0 -> ld never asserts; the DONE cycle gives nak1=1 (macro on) or ack1=1 (macro off).
REQ-031 Reset mid-EXEC: rst=1 in the EXEC cycle -> INIT next (clr=1), no ack, last=1.
REQ-032 Late flag change: CM toggles 1->0 during EXEC -> ld still issued, ack0 still issued.
